up_frame_sched: RTL and testbench

Upload frame scheduler. It takes the single-cycle send enables for fault, DC voltage, cell state and frequency, and arbitrates them onto one shared byte-wide UART transmitter. For each granted request it emits a complete frame: header, type, length, payload fetched from the upload buffer RAM, and checksum. It sits between the upload enable generator and the UART TX core.

---
 rtl/up_pkg.sv | 37 +++
 rtl/up_req_arb.sv | 47 ++++
 rtl/up_frame_sched.sv | 150 +++++++++++++++
 tb/tb_up_frame_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/up_pkg.sv
// rtl/up_pkg.sv - shared types and defaults for the upload frame scheduler (UP_CHKSUM_EN adds ST_SUM)
package up_pkg;

  localparam int TYPE_W = 2;
  localparam int IDX_W  = 6;

  localparam logic [TYPE_W-1:0] TYPE_FAULT = 2'd0;
  localparam logic [TYPE_W-1:0] TYPE_VOLT  = 2'd1;
  localparam logic [TYPE_W-1:0] TYPE_STATE = 2'd2;
  localparam logic [TYPE_W-1:0] TYPE_FRE   = 2'd3;

  localparam logic [7:0] HEAD_BYTE_DEF = 8'hEB;

  localparam int FAULT_LEN_DEF = 8;
  localparam int VOLT_LEN_DEF  = 16;
  localparam int STATE_LEN_DEF = 12;
  localparam int FRE_LEN_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_TYPE,
    ST_LEN,
    ST_FETCH,
    ST_PAY,
`ifdef UP_CHKSUM_EN
    ST_SUM,
`endif
    ST_WAIT
  } up_state_e;

  // Payload RAM address: type code in the top bits, byte index below.
  function automatic logic [7:0] mk_addr(input logic [TYPE_W-1:0] t, input logic [IDX_W-1:0] idx);
    return {t, idx};
  endfunction

endpackage

// File: rtl/up_req_arb.sv
// rtl/up_req_arb.sv - pending/overrun flags and fixed-priority winner select for upload requests
module up_req_arb
  import up_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic              grant,
  input  logic              ovf_clr,
  output logic              pend_any,
  output logic [TYPE_W-1:0] win_type,
  output logic [3:0]        ovf
);

  logic [3:0] pend;
  logic [3:0] clr_mask;
  logic [3:0] ovr;

  // Grant clears only the winner; a request already waiting (and not being consumed) is an overrun.
  always_comb begin
    clr_mask = '0;
    if (grant) clr_mask[win_type] = 1'b1;
    ovr = req & pend & ~clr_mask;
  end

  // Pending set wins over grant clear; a fresh overrun wins over ovf_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ovf  <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | req;
      ovf  <= ovf_clr ? ovr : (ovf | ovr);
    end
  end

  // Fixed priority: fault > volt > state > fre.
  always_comb begin
    win_type = TYPE_FRE;
    if (pend[0])      win_type = TYPE_FAULT;
    else if (pend[1]) win_type = TYPE_VOLT;
    else if (pend[2]) win_type = TYPE_STATE;
  end

  assign pend_any = |pend;

endmodule

// File: rtl/up_frame_sched.sv
// rtl/up_frame_sched.sv - upload frame scheduler onto one UART TX (UP_CHKSUM_EN appends the checksum byte)
module up_frame_sched
  import up_pkg::*;
#(
  parameter logic [7:0] HEAD_BYTE = HEAD_BYTE_DEF,
  parameter int         FAULT_LEN = FAULT_LEN_DEF,
  parameter int         VOLT_LEN  = VOLT_LEN_DEF,
  parameter int         STATE_LEN = STATE_LEN_DEF,
  parameter int         FRE_LEN   = FRE_LEN_DEF
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fault_en,
  input  logic       volt_en,
  input  logic       state_en,
  input  logic       fre_en,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  input  logic       ovf_clr,
  output logic [3:0] ovf,
  output logic       sched_busy
);

  up_state_e         state, state_n, ret_state, ret_n;
  logic              grant, send, pend_any, last, wait_ign, pay_valid;
  logic [7:0]        send_byte, pay_byte, pay_data;
  logic [TYPE_W-1:0] win_type, cur_type;
  logic [IDX_W-1:0]  win_len, cur_len, byte_idx;
`ifdef UP_CHKSUM_EN
  logic [7:0]        sum;
`endif

  up_req_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({fre_en, state_en, volt_en, fault_en}),
    .grant    (grant),
    .ovf_clr  (ovf_clr),
    .pend_any (pend_any),
    .win_type (win_type),
    .ovf      (ovf)
  );

  // Payload length of the current arbitration winner.
  always_comb begin
    case (win_type)
      TYPE_FAULT: win_len = IDX_W'(FAULT_LEN);
      TYPE_VOLT:  win_len = IDX_W'(VOLT_LEN);
      TYPE_STATE: win_len = IDX_W'(STATE_LEN);
      default:    win_len = IDX_W'(FRE_LEN);
    endcase
  end

  assign pay_data   = pay_valid ? pay_byte : rd_data;
  assign last       = (byte_idx == cur_len - IDX_W'(1));
  assign rd_en      = (state == ST_FETCH);
  assign rd_addr    = mk_addr(cur_type, byte_idx);
  assign sched_busy = (state != ST_IDLE);

  // Next state and send decision; every send parks in WAIT with the state to resume in ret_n.
  always_comb begin
    state_n   = state;
    ret_n     = ret_state;
    grant     = 1'b0;
    send      = 1'b0;
    send_byte = '0;
    case (state)
      ST_IDLE: if (pend_any) begin
        grant   = 1'b1;
        state_n = ST_HEAD;
      end
      ST_HEAD: if (!tx_busy) begin
        send = 1'b1; send_byte = HEAD_BYTE; ret_n = ST_TYPE; state_n = ST_WAIT;
      end
      ST_TYPE: if (!tx_busy) begin
        send = 1'b1; send_byte = {6'd0, cur_type}; ret_n = ST_LEN; state_n = ST_WAIT;
      end
      ST_LEN: if (!tx_busy) begin
        send = 1'b1; send_byte = {2'd0, cur_len}; ret_n = ST_FETCH; state_n = ST_WAIT;
      end
      ST_FETCH: state_n = ST_PAY;
      ST_PAY: if (!tx_busy) begin
        send = 1'b1; send_byte = pay_data; state_n = ST_WAIT;
`ifdef UP_CHKSUM_EN
        ret_n = last ? ST_SUM : ST_FETCH;
`else
        ret_n = last ? ST_IDLE : ST_FETCH;
`endif
      end
`ifdef UP_CHKSUM_EN
      ST_SUM: if (!tx_busy) begin
        send = 1'b1; send_byte = sum; ret_n = ST_IDLE; state_n = ST_WAIT;
      end
`endif
      ST_WAIT: if (!wait_ign && !tx_busy) state_n = ret_state;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register and resume target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
    end
  end

  // Frame datapath: latched request, byte index, payload capture, UART handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start  <= 1'b0;
      tx_data   <= '0;
      wait_ign  <= 1'b0;
      cur_type  <= '0;
      cur_len   <= '0;
      byte_idx  <= '0;
      pay_valid <= 1'b0;
      pay_byte  <= '0;
    end else begin
      tx_start  <= send;
      wait_ign  <= send;
      pay_valid <= (state == ST_PAY);
      if (send) tx_data <= send_byte;
      if (grant) begin
        cur_type <= win_type;
        cur_len  <= win_len;
      end
      if (state == ST_IDLE)               byte_idx <= '0;
      else if (send && state == ST_PAY)   byte_idx <= byte_idx + IDX_W'(1);
      if (state == ST_PAY && !pay_valid)  pay_byte <= rd_data;
    end
  end

`ifdef UP_CHKSUM_EN
  // Checksum starts at type + len and accumulates each payload byte as it is sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         sum <= '0;
    else if (grant)                     sum <= {6'd0, win_type} + {2'd0, win_len};
    else if (send && state == ST_PAY)   sum <= sum + pay_data;
  end
`endif

endmodule

// File: tb/tb_up_frame_sched.sv
// tb/tb_up_frame_sched.sv - directed self-checking bench for up_frame_sched
module tb_up_frame_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fault_en, volt_en, state_en, fre_en;
  logic       tx_busy, tx_start, rd_en, ovf_clr, sched_busy, hold_busy;
  logic [7:0] tx_data, rd_addr, rd_data;
  logic [3:0] ovf;
  int         n_cmp = 0, n_err = 0, viol = 0, n_tx = 0, busy_cnt = 0, base;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];

  up_frame_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fault_en   (fault_en),
    .volt_en    (volt_en),
    .state_en   (state_en),
    .fre_en     (fre_en),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .ovf_clr    (ovf_clr),
    .ovf        (ovf),
    .sched_busy (sched_busy)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each tx_start; hold_busy forces it high.
  assign tx_busy = (busy_cnt != 0) || hold_busy;
  always @(posedge clk) begin
    if (tx_start)           busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Payload RAM model: byte i of every buffer is 8'h10 + i, one cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= 8'h10 + {2'b00, rd_addr[5:0]};

  // Byte capture and handshake monitor.
  always @(negedge clk) begin
    if (tx_start) begin
      cap.push_back(tx_data);
      n_tx++;
    end
    if (tx_start && (tx_busy || rd_en)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    {fre_en, state_en, volt_en, fault_en} = m;
    @(negedge clk);
    {fre_en, state_en, volt_en, fault_en} = 4'b0000;
  endtask

  task automatic add_frame(input int t, input int len);
    logic [7:0] s;
    s = 8'(t + len);
    exp_q.push_back(8'hEB);
    exp_q.push_back(8'(t));
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      s = s + 8'h10 + 8'(i);
    end
`ifdef UP_CHKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic wait_idle(input string tag);
    int lows = 0;
    int cyc = 0;
    while (lows < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      lows = sched_busy ? 0 : lows + 1;
    end
    chk({tag, "_idle"}, 32'(lows >= 3), 32'd1);
  endtask

  task automatic wait_cnt(input string tag, input int n);
    int cyc = 0;
    while (cap.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_count"}, 32'(cap.size() >= n), 32'd1);
  endtask

  task automatic chk_frames(input string tag);
    chk({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; hold_busy = 1'b0; ovf_clr = 1'b0; rd_data = '0;
    {fre_en, state_en, volt_en, fault_en} = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(sched_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single voltage frame with first-byte latency.
    add_frame(1, 16);
    pulse(4'b0010);
    chk("lat_idle", 32'(sched_busy), 32'd0);
    @(negedge clk);
    chk("lat_grant_busy", 32'(sched_busy), 32'd1);
    chk("lat_grant_tx", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("lat_head_tx", 32'(tx_start), 32'd1);
    chk("lat_head_byte", 32'(tx_data), 32'hEB);
    wait_idle("volt");
    chk_frames("volt");

    // Simultaneous fault and fre: fault first, fre held then sent.
    add_frame(0, 8);
    add_frame(3, 4);
    pulse(4'b1001);
    wait_idle("prio");
    chk_frames("prio");

    // Re-request during a state frame, then an overrun.
    add_frame(2, 12);
    add_frame(2, 12);
    pulse(4'b0100);
    repeat (20) @(negedge clk);
    pulse(4'b0100);
    repeat (20) @(negedge clk);
    chk("ovf_requeue", 32'(ovf), 32'd0);
    pulse(4'b0100);
    chk("ovf_set", 32'(ovf), 32'h4);
    wait_idle("state");
    chk_frames("state");
    chk("ovf_sticky", 32'(ovf), 32'h4);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // UART busy held in HEAD.
    add_frame(3, 4);
    hold_busy = 1'b1;
    pulse(4'b1000);
    base = n_tx;
    repeat (50) @(negedge clk);
    chk("hold_no_tx", 32'(n_tx - base), 32'd0);
    chk("hold_busy", 32'(sched_busy), 32'd1);
    hold_busy = 1'b0;
    @(negedge clk);
    chk("hold_tx", 32'(tx_start), 32'd1);
    chk("hold_byte", 32'(tx_data), 32'hEB);
    @(negedge clk);
    chk("hold_single", 32'(tx_start), 32'd0);
    wait_idle("hold");
    chk_frames("hold");

    // Asynchronous reset after the fifth payload byte.
    pulse(4'b0010);
    wait_cnt("mid", 8);
    chk("mid_addr", 32'(rd_addr), 32'h45);
    chk("mid_data", 32'(tx_data), 32'h14);
    chk("mid_busy", 32'(sched_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_start", 32'(tx_start), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_busy", 32'(sched_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_tx;
    repeat (100) @(negedge clk);
    chk("post_rst_quiet", 32'(n_tx - base), 32'd0);
    chk("post_rst_idle", 32'(sched_busy), 32'd0);
    cap.delete();

    chk("handshake", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
